// File: rtl/eth_pkg.sv
// eth_pkg: shared types and defaults for the Ethernet forwarding stage
package eth_pkg;
    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] PORT0_ID_DEF = 8'h01;
    localparam logic [ID_W-1:0] PORT1_ID_DEF = 8'h02;

    typedef struct packed {
        logic [31:0] data;
        logic        start;
        logic        last;
    } fifo_word_t;

    typedef enum logic [1:0] {IN_IDLE, IN_REQ, IN_FWD, IN_DROP} in_state_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;
endpackage

// File: rtl/eth_fwd_arb.sv
// eth_fwd_arb: two-requester packet-granular round-robin arbiter for one output
module eth_fwd_arb
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [0:1] req,
    input  logic       rel,
    output logic [0:1] gnt
);
    arb_state_t state;
    logic       last_gnt;
    logic       pick;

    assign pick = (req[0] && req[1]) ? ~last_gnt : req[1];
    assign gnt  = {state == ARB_GNT0, state == ARB_GNT1};

    // decide only when idle; a grant is held until its packet releases it
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            last_gnt <= 1'b1;
        end else if (state == ARB_IDLE) begin
            if (req[0] || req[1]) begin
                state    <= pick ? ARB_GNT1 : ARB_GNT0;
                last_gnt <= pick;
            end
        end else if (rel) begin
            state <= ARB_IDLE;
        end
    end
endmodule

// File: rtl/eth_fwd.sv
// eth_fwd: routes whole packets from two ingress FIFOs to two output ports
module eth_fwd #(
    parameter int                ID_W     = eth_pkg::ID_W,
    parameter logic [ID_W-1:0]   PORT0_ID = eth_pkg::PORT0_ID_DEF,
    parameter logic [ID_W-1:0]   PORT1_ID = eth_pkg::PORT1_ID_DEF,
    parameter int                CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [33:0]      fifo_rd_data [0:1],
    input  logic             fifo_empty   [0:1],
    output logic             fifo_rd_en   [0:1],
    output logic [31:0]      o_data       [0:1],
    output logic             o_valid      [0:1],
    output logic             o_start      [0:1],
    output logic             o_end        [0:1],
    output logic [CNT_W-1:0] drop_cnt     [0:1]
);
    import eth_pkg::*;

    fifo_word_t head [0:1];
    in_state_t  state [0:1];
    logic       tgt [0:1];
    logic       known [0:1];
    logic       mine [0:1];
    logic       fwd_pop [0:1];
    logic       trunc [0:1];
    logic       drop_start [0:1];
    logic [0:1] req [0:1];
    logic [0:1] gnt [0:1];
    logic [0:1] rel;
    logic       ov [0:1];
    fifo_word_t ow [0:1];

    // pop decisions per input, arbiter requests/releases and output word select per port
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            head[i]       = fifo_rd_data[i];
            known[i]      = head[i].data[ID_W-1:0] == PORT0_ID || head[i].data[ID_W-1:0] == PORT1_ID;
            mine[i]       = gnt[tgt[i]][i];
            fwd_pop[i]    = !fifo_empty[i] && ((state[i] == IN_REQ && mine[i]) || (state[i] == IN_FWD && !head[i].start));
            trunc[i]      = !fifo_empty[i] && state[i] == IN_FWD && head[i].start;
            drop_start[i] = !fifo_empty[i] && state[i] == IN_IDLE && head[i].start && !known[i];
            fifo_rd_en[i] = !rst && (fwd_pop[i] || drop_start[i] ||
                            (!fifo_empty[i] && !head[i].start && (state[i] == IN_IDLE || state[i] == IN_DROP)));
        end
        for (int o = 0; o < 2; o++) begin
            req[o] = {state[0] == IN_REQ && tgt[0] == 1'(o), state[1] == IN_REQ && tgt[1] == 1'(o)};
            rel[o] = (tgt[0] == 1'(o) && ((fwd_pop[0] && head[0].last) || trunc[0])) ||
                     (tgt[1] == 1'(o) && ((fwd_pop[1] && head[1].last) || trunc[1]));
            ov[o]  = (fwd_pop[0] && tgt[0] == 1'(o)) || (fwd_pop[1] && tgt[1] == 1'(o));
            ow[o]  = (fwd_pop[1] && tgt[1] == 1'(o)) ? head[1] : head[0];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_arb
        eth_fwd_arb u_arb (
            .clk (clk),
            .rst (rst),
            .req (req[g]),
            .rel (rel[g]),
            .gnt (gnt[g])
        );
    end

    // per-input packet state machine and saturating drop counter
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                state[i]    <= IN_IDLE;
                tgt[i]      <= 1'b0;
                drop_cnt[i] <= '0;
            end else begin
                if (drop_start[i] && drop_cnt[i] != {CNT_W{1'b1}})
                    drop_cnt[i] <= drop_cnt[i] + 1'b1;
                case (state[i])
                    IN_IDLE: if (!fifo_empty[i] && head[i].start) begin
                        tgt[i]   <= head[i].data[ID_W-1:0] == PORT1_ID;
                        state[i] <= known[i] ? IN_REQ : head[i].last ? IN_IDLE : IN_DROP;
                    end
                    IN_REQ: if (mine[i])
                        state[i] <= (fwd_pop[i] && head[i].last) ? IN_IDLE : IN_FWD;
                    default: if (!fifo_empty[i] && (head[i].start || head[i].last))
                        state[i] <= IN_IDLE;
                endcase
            end
        end
    end

    // output registers: a popped word appears the following cycle, data holds otherwise
    always_ff @(posedge clk) begin
        for (int o = 0; o < 2; o++) begin
            if (rst) begin
                o_data[o]  <= '0;
                o_valid[o] <= 1'b0;
                o_start[o] <= 1'b0;
                o_end[o]   <= 1'b0;
            end else begin
                o_valid[o] <= ov[o];
                o_start[o] <= ov[o] && ow[o].start;
                o_end[o]   <= ov[o] && ow[o].last;
                if (ov[o])
                    o_data[o] <= ow[o].data;
            end
        end
    end
endmodule

// File: tb/tb_eth_fwd.sv
// tb_eth_fwd: scoreboard bench for eth_fwd with modelled show-ahead ingress FIFOs
module tb_eth_fwd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [33:0] fifo_rd_data [0:1];
    logic        fifo_empty   [0:1];
    logic        fifo_rd_en   [0:1];
    logic [31:0] o_data       [0:1];
    logic        o_valid      [0:1];
    logic        o_start      [0:1];
    logic        o_end        [0:1];
    logic [15:0] drop_cnt     [0:1];

    logic [33:0] q0[$], q1[$], exp0[$], exp1[$];
    logic [1:0]  en_s = 2'b00;
    logic [33:0] mon_want;
    int n_vec = 0, n_err = 0, cyc = 0;
    int pops [0:1] = '{0, 0};
    int start_cyc [0:1] = '{0, 0};
    int last_end [0:1] = '{0, 0};
    int gap [0:1] = '{0, 0};
    int t0, p, k;

    eth_fwd dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_start      (o_start),
        .o_end        (o_end),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // FIFO head/empty follow the queues shortly after every clock edge
    always @(clk) begin
        #1;
        fifo_empty[0]   = q0.size() == 0;
        fifo_empty[1]   = q1.size() == 0;
        fifo_rd_data[0] = q0.size() != 0 ? q0[0] : 34'd0;
        fifo_rd_data[1] = q1.size() != 0 ? q1[0] : 34'd0;
    end

    always @(negedge clk) begin
        #4;
        en_s = {fifo_rd_en[1], fifo_rd_en[0]};
    end

    always @(posedge clk) begin
        if (en_s[0]) begin
            if (q0.size() == 0) begin n_vec++; n_err++; $display("FAIL pop_empty0: got pop, required none"); end
            else begin void'(q0.pop_front()); pops[0]++; end
        end
        if (en_s[1]) begin
            if (q1.size() == 0) begin n_vec++; n_err++; $display("FAIL pop_empty1: got pop, required none"); end
            else begin void'(q1.pop_front()); pops[1]++; end
        end
    end

    // monitor: every valid output word must match the head of that port's expected queue
    always @(negedge clk) begin
        if (!rst) begin
            for (int o = 0; o < 2; o++) begin
                if (o_valid[o]) begin
                    if ((o == 0 ? exp0.size() : exp1.size()) == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL out%0d_unexpected: got %h, required no word", o, {o_data[o], o_start[o], o_end[o]});
                    end else begin
                        if (o == 0) mon_want = exp0.pop_front();
                        else mon_want = exp1.pop_front();
                        chk($sformatf("out%0d_word", o), {o_data[o], o_start[o], o_end[o]}, mon_want);
                    end
                    if (o_start[o]) begin gap[o] = cyc - last_end[o]; start_cyc[o] = cyc; end
                    if (o_end[o]) last_end[o] = cyc;
                end else begin
                    chk($sformatf("out%0d_idle_flags", o), {o_start[o], o_end[o]}, 0);
                end
            end
        end
    end

    task automatic send(input int i, input int o, input logic [7:0] dest, input int n,
                        input logic [31:0] base, input bit cut);
        logic [31:0] d;
        logic [33:0] w;
        for (int j = 0; j < n; j++) begin
            d = j == 0 ? {base[31:8], dest} : base + j;
            w = {d, j == 0, (j == n - 1) && !cut};
            if (i == 0) q0.push_back(w); else q1.push_back(w);
            if (o == 0) exp0.push_back(w); else if (o == 1) exp1.push_back(w);
        end
    endtask

    task automatic drain(input int bound);
        int j;
        for (j = 0; j < bound; j++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && exp0.size() == 0 && exp1.size() == 0) break;
        end
        chk("drain_in_time", j < bound, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_o_valid0", o_valid[0], 0);
        chk("rst_o_valid1", o_valid[1], 0);
        chk("rst_o_data0", o_data[0], 0);
        chk("rst_drop_cnt0", drop_cnt[0], 0);
        chk("rst_drop_cnt1", drop_cnt[1], 0);
        chk("rst_rd_en0", fifo_rd_en[0], 0);
        #1 rst = 1'b0;
        @(negedge clk);

        t0 = cyc;
        send(0, 1, 8'h02, 4, 32'hA100_0000, 0);
        drain(100);
        chk("t1_latency", start_cyc[1], t0 + 3);
        chk("t1_burst_len", last_end[1] - start_cyc[1], 3);

        send(0, 0, 8'h01, 3, 32'hB000_0000, 0);
        send(1, 0, 8'h01, 2, 32'hB100_0000, 0);
        drain(100);
        chk("t2_gap", gap[0], 2);
        send(0, 0, 8'h01, 1, 32'hB200_0000, 0);
        drain(100);
        send(1, 0, 8'h01, 2, 32'hB300_0000, 0);
        send(0, 0, 8'h01, 2, 32'hB400_0000, 0);
        drain(100);
        chk("t2_rr_gap", gap[0], 2);

        t0 = cyc;
        send(0, 1, 8'h02, 3, 32'hC000_0000, 0);
        send(1, 0, 8'h01, 3, 32'hC100_0000, 0);
        drain(100);
        chk("t3_lat_out0", start_cyc[0], t0 + 3);
        chk("t3_lat_out1", start_cyc[1], t0 + 3);

        p = pops[0];
        send(0, -1, 8'h55, 3, 32'hD000_0000, 0);
        drain(100);
        chk("t4_drop_pops", pops[0] - p, 3);
        chk("t4_drop_cnt0", drop_cnt[0], 1);
        chk("t4_drop_cnt1", drop_cnt[1], 0);

        p = pops[0];
        q0.push_back({32'hDEAD_0001, 1'b0, 1'b0});
        drain(100);
        chk("t5_orphan_pops", pops[0] - p, 1);
        chk("t5_orphan_cnt", drop_cnt[0], 1);

        send(0, 0, 8'h01, 3, 32'hE000_0000, 1);
        send(0, 1, 8'h02, 3, 32'hE100_0000, 0);
        drain(100);
        chk("t6_trunc_cnt", drop_cnt[0], 1);

        for (int j = 0; j < 65535; j++) q1.push_back({32'h0000_0055, 1'b1, 1'b1});
        drain(70000);
        chk("t7_cnt_max", drop_cnt[1], 16'hFFFF);
        q1.push_back({32'h0000_0055, 1'b1, 1'b1});
        q1.push_back({32'h0000_0055, 1'b1, 1'b1});
        drain(100);
        chk("t7_cnt_sat", drop_cnt[1], 16'hFFFF);

        p = pops[0];
        send(0, 0, 8'h01, 5, 32'hF000_0000, 0);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_valid[0] && o_start[0]) break;
        end
        chk("t8_start_seen", k < 20, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        exp0.delete();
        @(negedge clk);
        chk("t8_o_valid0", o_valid[0], 0);
        chk("t8_o_start0", o_start[0], 0);
        chk("t8_o_end0", o_end[0], 0);
        chk("t8_o_data0", o_data[0], 0);
        chk("t8_o_data1", o_data[1], 0);
        chk("t8_rd_en0", fifo_rd_en[0], 0);
        chk("t8_drop_cnt1", drop_cnt[1], 0);
        #1 rst = 1'b0;
        drain(100);
        chk("t8_all_popped", pops[0] - p, 5);
        chk("t8_drop_cnt0", drop_cnt[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
